conv_train_sched: RTL and testbench

Sequencer for one convolution layer's forward and backward engines. It runs a programmed number of training iterations per command: forward pass, wait for the downstream error, backward pass, then a kernel-update sweep. Inference mode runs forward passes only. It sits between the host/top-level control and the engine pair, and provides engine clearing, a watchdog and abort.

---
 rtl/conv_train_sched.sv | 195 +++++++++++++++++++
 tb/tb_conv_train_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_train_sched.sv
// Training-iteration sequencer for one convolution layer: forward pass, wait for
// downstream error, backward pass, kernel-update sweep; with watchdog and abort.
module conv_train_sched #(
  parameter int IMG_HEIGHT = 64,
  parameter int IMG_WIDTH  = 64,
  parameter int KERNEL     = 3,
  parameter int TIMEOUT    = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_train,
  input  logic [15:0] num_iter,
  input  logic        abort,
  output logic        fwd_rst,
  output logic        fwd_start,
  input  logic        fwd_done,
  output logic        bwd_rst,
  output logic        bwd_start,
  input  logic        bwd_done,
  output logic        fmap_valid,
  input  logic        err_valid,
  output logic        upd_en,
  output logic [3:0]  upd_row,
  output logic [3:0]  upd_col,
  output logic [15:0] iter_count,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] KLAST = 4'(KERNEL - 1);

  if (KERNEL < 1 || KERNEL > 15 || KERNEL > IMG_WIDTH || KERNEL > IMG_HEIGHT) begin : g_bad_geom
    $error("conv_train_sched: kernel does not fit the image geometry");
  end

  typedef enum logic [3:0] {
    IDLE, FWD_CLR, FWD_RUN, WAIT_ERR, BWD_CLR, BWD_RUN, UPDATE, ITER_END, FAULT
  } state_t;

  state_t           state;
  logic             train_q;
  logic [15:0]      iter_tgt;
  logic [WDW-1:0]   wd;
  logic             wd_hit;
  logic [16:0]      iter_nxt;
  logic             last_iter;

  // wd holds the number of RUN cycles already elapsed, so the TIMEOUT-th cycle faults
  assign wd_hit    = (wd == WDW'(TIMEOUT - 1));
  assign iter_nxt  = {1'b0, iter_count} + 17'd1;
  assign last_iter = (iter_nxt >= {1'b0, iter_tgt});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      train_q    <= 1'b0;
      iter_tgt   <= '0;
      wd         <= '0;
      fwd_rst    <= 1'b0;
      fwd_start  <= 1'b0;
      bwd_rst    <= 1'b0;
      bwd_start  <= 1'b0;
      fmap_valid <= 1'b0;
      upd_en     <= 1'b0;
      upd_row    <= '0;
      upd_col    <= '0;
      iter_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      fwd_rst    <= 1'b0;
      fwd_start  <= 1'b0;
      bwd_rst    <= 1'b0;
      bwd_start  <= 1'b0;
      fmap_valid <= 1'b0;
      upd_en     <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b1;
      if (abort) begin
        state   <= IDLE;
        fwd_rst <= 1'b1;
        bwd_rst <= 1'b1;
        fault   <= 1'b0;
        busy    <= 1'b0;
        upd_row <= '0;
        upd_col <= '0;
        wd      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_start) begin
              train_q    <= cmd_train;
              iter_tgt   <= (num_iter == 16'd0) ? 16'd1 : num_iter;
              iter_count <= '0;
              fwd_rst    <= 1'b1;
              state      <= FWD_CLR;
            end else begin
              busy <= 1'b0;
            end
          end
          FWD_CLR: begin
            wd        <= '0;
            fwd_start <= 1'b1;
            state     <= FWD_RUN;
          end
          // done wins over a simultaneous watchdog expiry
          FWD_RUN: begin
            if (fwd_done) begin
              if (train_q) begin
                fmap_valid <= 1'b1;
                state      <= WAIT_ERR;
              end else begin
                iter_count <= iter_nxt[15:0];
                done       <= last_iter;
                state      <= ITER_END;
              end
            end else if (wd_hit) begin
              fault <= 1'b1;
              busy  <= 1'b0;
              state <= FAULT;
            end else begin
              wd        <= wd + 1'b1;
              fwd_start <= 1'b1;
            end
          end
          WAIT_ERR: begin
            if (err_valid) begin
              bwd_rst <= 1'b1;
              state   <= BWD_CLR;
            end else begin
              fmap_valid <= 1'b1;
            end
          end
          BWD_CLR: begin
            wd        <= '0;
            bwd_start <= 1'b1;
            state     <= BWD_RUN;
          end
          BWD_RUN: begin
            if (bwd_done) begin
              upd_en  <= 1'b1;
              upd_row <= '0;
              upd_col <= '0;
              state   <= UPDATE;
            end else if (wd_hit) begin
              fault <= 1'b1;
              busy  <= 1'b0;
              state <= FAULT;
            end else begin
              wd        <= wd + 1'b1;
              bwd_start <= 1'b1;
            end
          end
          UPDATE: begin
            if (upd_row == KLAST && upd_col == KLAST) begin
              upd_row    <= '0;
              upd_col    <= '0;
              iter_count <= iter_nxt[15:0];
              done       <= last_iter;
              state      <= ITER_END;
            end else begin
              upd_en <= 1'b1;
              if (upd_col == KLAST) begin
                upd_col <= '0;
                upd_row <= upd_row + 4'd1;
              end else begin
                upd_col <= upd_col + 4'd1;
              end
            end
          end
          // done was already raised on entry when this was the final iteration
          ITER_END: begin
            if (done) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              fwd_rst <= 1'b1;
              state   <= FWD_CLR;
            end
          end
          FAULT: busy <= 1'b0;
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_train_sched.sv
// Bench for conv_train_sched: 6x6 image, 3x3 kernel, short watchdog, simple
// engine models; table vectors, random commands vs. a count-level model, corner sequences.
module tb_conv_train_sched;

  localparam int IH = 6;
  localparam int IW = 6;
  localparam int K  = 3;
  localparam int TO = 20;
  localparam int ENG_LAT = (IW - K + 1) * (IH - K + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start, cmd_train, abort, err_valid;
  logic [15:0] num_iter;
  logic        fwd_rst, fwd_start, bwd_rst, bwd_start, fmap_valid, upd_en;
  logic        fwd_done = 1'b0;
  logic        bwd_done = 1'b0;
  logic [3:0]  upd_row, upd_col;
  logic [15:0] iter_count;
  logic        busy, done, fault;

  conv_train_sched #(.IMG_HEIGHT(IH), .IMG_WIDTH(IW), .KERNEL(K), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_train(cmd_train),
    .num_iter(num_iter), .abort(abort), .fwd_rst(fwd_rst), .fwd_start(fwd_start),
    .fwd_done(fwd_done), .bwd_rst(bwd_rst), .bwd_start(bwd_start), .bwd_done(bwd_done),
    .fmap_valid(fmap_valid), .err_valid(err_valid), .upd_en(upd_en), .upd_row(upd_row),
    .upd_col(upd_col), .iter_count(iter_count), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  // engine models: done (sticky) after ENG_LAT cycles of start, cleared by their rst
  logic fwd_hang = 1'b0;
  int   fcnt = 0;
  int   bcnt = 0;
  always @(posedge clk) begin
    if (fwd_rst) begin
      fcnt <= 0; fwd_done <= 1'b0;
    end else if (fwd_start) begin
      fcnt <= fcnt + 1;
      if (fcnt + 1 >= ENG_LAT && !fwd_hang) fwd_done <= 1'b1;
    end
    if (bwd_rst) begin
      bcnt <= 0; bwd_done <= 1'b0;
    end else if (bwd_start) begin
      bcnt <= bcnt + 1;
      if (bcnt + 1 >= ENG_LAT) bwd_done <= 1'b1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int c_fwd, c_bwd, c_upd, c_fmap, c_frst, c_brst, c_done, idx_bad, it_done;

  typedef struct {
    bit tr; int n; int d; bit poke;
    int e_it; int e_fwd; int e_bwd; int e_upd; int e_fmap; int e_brst;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_cmd(input bit tr, input int n);
    @(negedge clk);
    cmd_train = tr; num_iter = 16'(n); cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  // Runs one command to its done pulse, tallying what the engines and host see.
  task automatic do_cmd(input bit tr, input int n, input int d, input bit poke);
    int k, fvc;
    bit fin;
    c_fwd = 0; c_bwd = 0; c_upd = 0; c_fmap = 0; c_frst = 0; c_brst = 0;
    c_done = 0; idx_bad = 0; it_done = -1;
    pulse_cmd(tr, n);
    fin = 1'b0; k = 0; fvc = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      cmd_start = 1'b0;
      if (poke && fwd_start && c_fwd == 5) begin
        cmd_start = 1'b1; num_iter = 16'd9; cmd_train = ~tr;
      end
      if (fwd_rst) begin c_frst++; k = 0; end
      if (bwd_rst) c_brst++;
      if (fwd_start) c_fwd++;
      if (bwd_start) c_bwd++;
      if (fmap_valid) begin
        c_fmap++; err_valid = (fvc >= d); fvc++;
      end else begin
        err_valid = 1'b0; fvc = 0;
      end
      if (upd_en) begin
        if (upd_row != 4'(k / K) || upd_col != 4'(k % K)) idx_bad++;
        k++; c_upd++;
      end
      if (done) begin
        c_done++; it_done = int'(iter_count); fin = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    cmd_start = 1'b0; err_valid = 1'b0;
    if (!fin) chk("cmd_completes", 0, 1);
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 0);
  endtask

  task automatic check_stats(input int e_it, input int e_fwd, input int e_bwd,
                             input int e_upd, input int e_fmap, input int e_brst);
    chk("iter_count_at_done", it_done, e_it);
    chk("fwd_start_cycles", c_fwd, e_fwd);
    chk("bwd_start_cycles", c_bwd, e_bwd);
    chk("upd_en_cycles", c_upd, e_upd);
    chk("fmap_valid_cycles", c_fmap, e_fmap);
    chk("fwd_rst_pulses", c_frst, e_it);
    chk("bwd_rst_pulses", c_brst, e_brst);
    chk("done_pulses", c_done, 1);
    chk("upd_index_errors", idx_bad, 0);
  endtask

  initial begin
    vec_t tbl[5];
    bit   tr, found;
    int   n, d, eff, lat, cnt;

    tbl[0] = '{0, 1, 0, 0, 1, 17, 0,  0,  0,  0};
    tbl[1] = '{1, 2, 5, 0, 2, 34, 34, 18, 12, 2};
    tbl[2] = '{1, 0, 2, 0, 1, 17, 17, 9,  3,  1};
    tbl[3] = '{0, 3, 0, 1, 3, 51, 0,  0,  0,  0};
    tbl[4] = '{0, 1, 0, 1, 1, 17, 0,  0,  0,  0};

    rst = 1'b0; cmd_start = 1'b0; cmd_train = 1'b0; num_iter = '0;
    abort = 1'b0; err_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {fwd_rst, fwd_start, bwd_rst, bwd_start, fmap_valid, upd_en,
                          upd_row, upd_col, iter_count, busy, done, fault}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {fwd_rst, fwd_start, bwd_rst, bwd_start, fmap_valid, upd_en,
                         upd_row, upd_col, iter_count, busy, done, fault}, 0);

    for (int i = 0; i < 5; i++) begin
      do_cmd(tbl[i].tr, tbl[i].n, tbl[i].d, tbl[i].poke);
      check_stats(tbl[i].e_it, tbl[i].e_fwd, tbl[i].e_bwd, tbl[i].e_upd,
                  tbl[i].e_fmap, tbl[i].e_brst);
    end

    // random commands; expectations from iteration-level arithmetic
    lat = ENG_LAT + 1;
    for (int i = 0; i < 6; i++) begin
      tr = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 4));
      eff = (n == 0) ? 1 : n;
      do_cmd(tr, n, d, 1'b0);
      check_stats(eff, eff * lat, tr ? eff * lat : 0, tr ? eff * K * K : 0,
                  tr ? eff * (d + 1) : 0, tr ? eff : 0);
    end

    // forward engine hangs: watchdog fault, then abort recovers
    fwd_hang = 1'b1;
    pulse_cmd(1'b0, 1);
    cnt = 0;
    for (int cyc = 0; cyc < 200 && !fault; cyc++) begin
      if (fwd_start) cnt++;
      @(negedge clk);
    end
    chk("timeout_run_cycles", cnt, TO);
    chk("fault_state", {fault, busy, fwd_start, bwd_start}, 4'b1000);
    fwd_hang = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_from_fault", {fwd_rst, bwd_rst, fault, busy}, 4'b1100);
    cmd_start = 1'b1; cmd_train = 1'b0; num_iter = 16'd1;
    @(negedge clk);
    chk("abort_held_blocks_cmd", {busy, fwd_start}, 0);
    abort = 1'b0; cmd_start = 1'b0;
    @(negedge clk);
    chk("idle_after_abort", {fwd_rst, bwd_rst, busy, fault}, 0);

    // abort mid-update at element (1,1)
    pulse_cmd(1'b1, 2);
    found = 1'b0;
    for (int cyc = 0; cyc < 400 && !found; cyc++) begin
      err_valid = fmap_valid;
      if (upd_en && upd_row == 4'd1 && upd_col == 4'd1) found = 1'b1;
      else @(negedge clk);
    end
    err_valid = 1'b0;
    chk("reached_upd_1_1", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_update", {upd_en, busy, done, fwd_rst, bwd_rst}, 5'b00011);
    chk("abort_keeps_iter", iter_count, 0);
    cnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done || busy) cnt++;
      @(negedge clk);
    end
    chk("no_done_after_abort", cnt, 0);
    do_cmd(1'b1, 1, 1, 1'b0);
    check_stats(1, lat, lat, K * K, 2, 1);

    // asynchronous reset during the backward pass
    pulse_cmd(1'b1, 1);
    found = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      err_valid = fmap_valid;
      if (bwd_start) found = 1'b1;
      else @(negedge clk);
    end
    err_valid = 1'b0;
    chk("reached_bwd_run", found, 1);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {fwd_rst, fwd_start, bwd_rst, bwd_start, fmap_valid, upd_en,
                                   upd_row, upd_col, iter_count, busy, done, fault}, 0);
    @(negedge clk);
    rst = 1'b1;
    do_cmd(1'b0, 2, 0, 1'b0);
    check_stats(2, 2 * lat, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
